// File: rtl/cd_tick_gen.sv
// Clock-divider counter stage: turns shadowed UART/VGA divider limits into
// single-cycle clock-enable ticks on the system clock.
module cd_tick_gen #(
   parameter int unsigned WIDTH_UART_CLK_LIMIT = 16,
   parameter int unsigned WIDTH_VGA_CLK_LIMIT  = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [WIDTH_UART_CLK_LIMIT-1:0] baudrate,
   input  logic [WIDTH_VGA_CLK_LIMIT-1:0]  resolution,
   input  logic                            c_UART_ready,
   input  logic                            c_VGA_ready,
   output logic                            uart_tick,
   output logic                            uart_mid_tick,
   output logic                            vga_tick,
   output logic [WIDTH_UART_CLK_LIMIT-1:0] uart_limit,
   output logic [WIDTH_VGA_CLK_LIMIT-1:0]  vga_limit
);

   localparam int unsigned UW = WIDTH_UART_CLK_LIMIT;
   localparam int unsigned VW = WIDTH_VGA_CLK_LIMIT;

   logic          uart_rs;
   logic          vga_rs;
   logic [UW-1:0] uart_cnt;
   logic [VW-1:0] vga_cnt;

   assign uart_rs = !c_UART_ready;
   assign vga_rs  = !c_VGA_ready;

   // UART channel: the limit reloads only at wrap or restart, so the count never passes it
   always_ff @(posedge clk) begin
      if (rst || uart_rs) begin
         uart_cnt      <= '0;
         uart_limit    <= baudrate;
         uart_tick     <= 1'b0;
         uart_mid_tick <= 1'b0;
      end else begin
         uart_mid_tick <= (uart_cnt == (uart_limit >> 1));
         if (uart_cnt == uart_limit) begin
            uart_cnt   <= '0;
            uart_limit <= baudrate;
            uart_tick  <= 1'b1;
         end else begin
            uart_cnt  <= uart_cnt + UW'(1);
            uart_tick <= 1'b0;
         end
      end
   end

   // VGA channel: same structure, independent restart
   always_ff @(posedge clk) begin
      if (rst || vga_rs) begin
         vga_cnt   <= '0;
         vga_limit <= resolution;
         vga_tick  <= 1'b0;
      end else if (vga_cnt == vga_limit) begin
         vga_cnt   <= '0;
         vga_limit <= resolution;
         vga_tick  <= 1'b1;
      end else begin
         vga_cnt  <= vga_cnt + VW'(1);
         vga_tick <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cd_tick_gen.sv
// Self-checking bench for cd_tick_gen: vector table, countdown reference model
// feeding a scoreboard queue, and timed sequences for period/restart corners.
module tb_cd_tick_gen;

   localparam int unsigned UW = 16;
   localparam int unsigned VW = 4;

   typedef struct packed {
      logic          ut;
      logic          um;
      logic          vt;
      logic [UW-1:0] ul;
      logic [VW-1:0] vl;
   } exp_t;

   typedef struct packed {
      logic          rst;
      logic          urdy;
      logic          vrdy;
      logic [UW-1:0] baud;
      logic [VW-1:0] res;
      exp_t          e;
   } vec_t;

   logic          clk;
   logic          rst;
   logic [UW-1:0] baudrate;
   logic [VW-1:0] resolution;
   logic          c_UART_ready;
   logic          c_VGA_ready;
   logic          uart_tick;
   logic          uart_mid_tick;
   logic          vga_tick;
   logic [UW-1:0] uart_limit;
   logic [VW-1:0] vga_limit;

   int n_pass   = 0;
   int n_checks = 0;

   exp_t exp_q[$];

   // countdown reference: rem = edges left before the ticking edge
   logic [UW-1:0] m_urem = '0;
   logic [UW-1:0] m_ulim = '0;
   logic [VW-1:0] m_vrem = '0;
   logic [VW-1:0] m_vlim = '0;

   cd_tick_gen #(
      .WIDTH_UART_CLK_LIMIT(UW),
      .WIDTH_VGA_CLK_LIMIT (VW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .baudrate     (baudrate),
      .resolution   (resolution),
      .c_UART_ready (c_UART_ready),
      .c_VGA_ready  (c_VGA_ready),
      .uart_tick    (uart_tick),
      .uart_mid_tick(uart_mid_tick),
      .vga_tick     (vga_tick),
      .uart_limit   (uart_limit),
      .vga_limit    (vga_limit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete (checks %0d)", n_checks);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, want);
   endtask

   function automatic vec_t mk(input logic r, input logic ur, input logic vr,
                               input int b, input int s, input logic ut,
                               input logic um, input logic vt, input int ul, input int vl);
      vec_t v;
      v.rst  = r;
      v.urdy = ur;
      v.vrdy = vr;
      v.baud = UW'(b);
      v.res  = VW'(s);
      v.e.ut = ut;
      v.e.um = um;
      v.e.vt = vt;
      v.e.ul = UW'(ul);
      v.e.vl = VW'(vl);
      return v;
   endfunction

   // one clock: model predicts, scoreboard holds the prediction until the DUT result is sampled
   task automatic cycle(input bit use_ov, input exp_t ov, input string name);
      exp_t e;
      exp_t got;
      exp_t want;
      if (rst || !c_UART_ready) begin
         m_ulim = baudrate;
         m_urem = baudrate;
         e.ut   = 1'b0;
         e.um   = 1'b0;
      end else begin
         e.ut = (m_urem == '0);
         e.um = ((m_ulim - m_urem) == (m_ulim >> 1));
         if (m_urem == '0) begin
            m_ulim = baudrate;
            m_urem = baudrate;
         end else begin
            m_urem = m_urem - UW'(1);
         end
      end
      if (rst || !c_VGA_ready) begin
         m_vlim = resolution;
         m_vrem = resolution;
         e.vt   = 1'b0;
      end else begin
         e.vt = (m_vrem == '0);
         if (m_vrem == '0) begin
            m_vlim = resolution;
            m_vrem = resolution;
         end else begin
            m_vrem = m_vrem - VW'(1);
         end
      end
      e.ul = m_ulim;
      e.vl = m_vlim;
      exp_q.push_back(use_ov ? ov : e);
      @(posedge clk);
      @(negedge clk);
      got.ut = uart_tick;
      got.um = uart_mid_tick;
      got.vt = vga_tick;
      got.ul = uart_limit;
      got.vl = vga_limit;
      want   = exp_q.pop_front();
      check(name, 64'(got), 64'(want));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, "cycle");
   endtask

   // sel: 0 = uart_tick, 1 = uart_mid_tick, 2 = vga_tick
   task automatic wait_tick(input int sel, input int budget, output int n);
      bit hit;
      hit = 1'b0;
      n   = 0;
      while (!hit && n < budget) begin
         cycle(1'b0, '0, "cycle");
         n++;
         case (sel)
            0:       hit = uart_tick;
            1:       hit = uart_mid_tick;
            default: hit = vga_tick;
         endcase
      end
      if (!hit) begin
         n_checks++;
         $display("FAIL wait_tick sel=%0d: no tick within %0d cycles", sel, budget);
      end
   endtask

   initial begin
      vec_t tbl[22];
      int   n;
      logic v0;

      rst          = 1'b1;
      c_UART_ready = 1'b1;
      c_VGA_ready  = 1'b1;
      baudrate     = UW'(2);
      resolution   = VW'(1);

      //          rst urdy vrdy baud res   ut um vt ul vl
      tbl[0]  = mk(1, 1, 1, 2, 1,  0, 0, 0, 2, 1);
      tbl[1]  = mk(0, 1, 1, 2, 1,  0, 0, 0, 2, 1);
      tbl[2]  = mk(0, 1, 1, 2, 1,  0, 1, 1, 2, 1);
      tbl[3]  = mk(0, 1, 1, 2, 1,  1, 0, 0, 2, 1);
      tbl[4]  = mk(0, 1, 1, 2, 1,  0, 0, 1, 2, 1);
      tbl[5]  = mk(0, 1, 1, 2, 1,  0, 1, 0, 2, 1);
      tbl[6]  = mk(0, 1, 1, 2, 1,  1, 0, 1, 2, 1);
      tbl[7]  = mk(0, 1, 1, 0, 0,  0, 0, 0, 2, 1);
      tbl[8]  = mk(0, 1, 1, 0, 0,  0, 1, 1, 2, 0);
      tbl[9]  = mk(0, 1, 1, 0, 0,  1, 0, 1, 0, 0);
      tbl[10] = mk(0, 1, 1, 0, 0,  1, 1, 1, 0, 0);
      tbl[11] = mk(0, 1, 1, 0, 0,  1, 1, 1, 0, 0);
      tbl[12] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      tbl[13] = mk(0, 1, 1, 3, 2,  1, 1, 1, 3, 2);
      tbl[14] = mk(0, 1, 1, 3, 2,  0, 0, 0, 3, 2);
      tbl[15] = mk(0, 1, 1, 3, 2,  0, 1, 0, 3, 2);
      tbl[16] = mk(0, 1, 1, 3, 2,  0, 0, 1, 3, 2);
      tbl[17] = mk(0, 1, 1, 3, 2,  1, 0, 0, 3, 2);
      tbl[18] = mk(1, 1, 1, 1, 1,  0, 0, 0, 1, 1);
      tbl[19] = mk(1, 0, 0, 1, 1,  0, 0, 0, 1, 1);
      tbl[20] = mk(0, 1, 1, 1, 1,  0, 1, 0, 1, 1);
      tbl[21] = mk(0, 1, 1, 1, 1,  1, 0, 1, 1, 1);

      foreach (tbl[i]) begin
         rst          = tbl[i].rst;
         c_UART_ready = tbl[i].urdy;
         c_VGA_ready  = tbl[i].vrdy;
         baudrate     = tbl[i].baud;
         resolution   = tbl[i].res;
         cycle(1'b1, tbl[i].e, $sformatf("vector%0d", i));
      end

      // reset release at 5207/1
      rst        = 1'b1;
      baudrate   = UW'(5207);
      resolution = VW'(1);
      cycle(1'b0, '0, "cycle");
      rst = 1'b0;
      wait_tick(1, 6000, n);  check("first_mid", 64'(n), 64'd2604);
      wait_tick(0, 6000, n);  check("first_tick", 64'(n), 64'd2604);
      wait_tick(1, 6000, n);  check("second_mid", 64'(n), 64'd2604);
      wait_tick(0, 6000, n);  check("second_tick", 64'(n), 64'd2604);
      wait_tick(2, 10, n);    check("vga_period", 64'(n), 64'd2);

      // baud change mid-period takes effect at the next wrap
      wait_tick(0, 6000, n);  check("tick_before_change", 64'(n), 64'd5206);
      run(100);
      baudrate = UW'(433);
      run(5107);
      check("limit_before_wrap", 64'(uart_limit), 64'd5207);
      check("no_early_tick", 64'(uart_tick), 64'd0);
      run(1);
      check("tick_at_wrap", 64'(uart_tick), 64'd1);
      check("limit_at_wrap", 64'(uart_limit), 64'd433);
      wait_tick(0, 600, n);   check("new_period_a", 64'(n), 64'd434);
      wait_tick(0, 600, n);   check("new_period_b", 64'(n), 64'd434);

      // one-cycle UART restart at count 3000
      baudrate = UW'(5207);
      wait_tick(0, 600, n);   check("reload_5207", 64'(n), 64'd434);
      run(3000);
      baudrate     = UW'(1301);
      c_UART_ready = 1'b0;
      cycle(1'b0, '0, "cycle");
      v0 = vga_tick;
      check("restart_no_tick", 64'(uart_tick), 64'd0);
      c_UART_ready = 1'b1;
      wait_tick(0, 1400, n);  check("after_restart", 64'(n), 64'd1302);
      check("restart_limit", 64'(uart_limit), 64'd1301);
      check("vga_phase_kept", 64'(vga_tick), 64'(v0));

      // VGA held in restart for 10 cycles with a new resolution
      c_VGA_ready = 1'b0;
      resolution  = VW'(3);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, '0, "cycle");
         check("vga_held", 64'(vga_tick), 64'd0);
      end
      c_VGA_ready = 1'b1;
      wait_tick(2, 10, n);    check("vga_resume", 64'(n), 64'd4);
      wait_tick(2, 10, n);    check("vga_period3", 64'(n), 64'd4);

      // one-cycle rst mid-period on both channels
      run(7);
      rst        = 1'b1;
      baudrate   = UW'(20);
      resolution = VW'(2);
      cycle(1'b0, '0, "cycle");
      check("rst_ticks", 64'({uart_tick, uart_mid_tick, vga_tick}), 64'd0);
      check("rst_ulimit", 64'(uart_limit), 64'd20);
      check("rst_vlimit", 64'(vga_limit), 64'd2);
      rst = 1'b0;
      wait_tick(2, 10, n);    check("rst_vga_first", 64'(n), 64'd3);
      wait_tick(1, 30, n);    check("rst_mid_first", 64'(n), 64'd8);
      wait_tick(0, 30, n);    check("rst_uart_first", 64'(n), 64'd10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
